uart_rx_core: RTL and testbench
===============================

// Module: uart_rx_core
// PURPOSE
//   Parametrised UART receiver that replaces the fixed 8N1 receiver. It adds configurable
//   frame format, a metastability synchroniser, mid-bit sampling, false-start rejection,
//   parity/framing error flags and a ready/valid output. It sits between the board RX pin
//   and the CPU MMIO UART register block.
// PARAMETERS
//   CLK_DIV     868  clk cycles per bit (100 MHz / 115200); legal range 4..65535
//   DATA_BITS   8    payload bits per frame, 5..9, LSB received first
//   PARITY      0    0 = none, 1 = odd, 2 = even
//   STOP_BITS   1    1 or 2
//   FIFO_DEPTH  8    entries; power of 2, 2..64; used only with UART_RX_FIFO_EN
// PORTS
//   clk         in   1          system clock
//   rst_n       in   1          asynchronous active-low reset
//   data_in     in   1          serial RX line, idle high, asynchronous to clk
//   data_out    out  DATA_BITS  received word (head entry)
//   valid       out  1          data_out, frame_err and parity_err are valid
//   ready       in   1          consumer accepts; the word pops when valid && ready
//   frame_err   out  1          head word had a low stop bit
//   parity_err  out  1          head word failed the parity check (always 0 if PARITY=0)
//   overrun     out  1          1-cycle pulse: a completed word was dropped
//   busy        out  1          FSM not in IDLE
// BEHAVIOUR
//   - Reset: the FSM enters IDLE; all counters are 0; the synchroniser flops are 1.
//     Outputs after reset: data_out=0, valid=0, frame_err=0, parity_err=0, overrun=0, busy=0.
//     Reset asserted mid-frame discards the partial frame and any stored words.
//   - data_in passes through a 2-FF synchroniser (rx_s). All references below use rx_s.
//   - Bit counter: counts 0..CLK_DIV-1 and wraps. The half-bit point is (CLK_DIV/2)-1,
//     using integer division.
//   - FSM states: IDLE, START, DATA, PAR, STOP.
//     IDLE : rx_s==0 -> START, counter cleared.
//     START: at the half-bit point, rx_s==1 -> IDLE (false start, nothing stored).
//            Otherwise -> DATA, counter cleared, so later samples land mid-bit.
//     DATA : sample at each count CLK_DIV-1, shifting LSB first. After DATA_BITS samples
//            go to PAR if PARITY!=0, else to STOP.
//     PAR  : sample one bit at CLK_DIV-1. Error if the XOR of data and parity bit is wrong
//            (odd: XOR must be 1; even: XOR must be 0).
//     STOP : sample STOP_BITS bits at CLK_DIV-1. Any low sample sets frame_err for the word.
//            After the last stop sample, push the word and go to IDLE the next cycle.
//            A start edge arriving in that same cycle is seen from IDLE; no bit time is lost.
//   - Latency: valid rises 1 clk after the final stop-bit sample.
//   - busy=1 in START, DATA, PAR and STOP.
//   - Error flags are stored with the word and are valid only while valid=1.
//   - Push and pop in the same cycle: the pop occurs and the push is accepted; no overrun.
//   - Break condition (rx_s held low): gives one word of 0 with frame_err=1. The FSM then
//     stays in IDLE until rx_s returns high before it re-arms start detection.
// CONFIGURATION
//   UART_RX_FIFO_EN defined:
//     - Words are stored in a FIFO_DEPTH-entry FIFO with wrap-around pointers.
//     - valid = !empty; data_out and the flags show the head entry.
//     - A push when full and not popping in the same cycle drops the new word and pulses
//       overrun. A push and pop in the same cycle at full is accepted.
//   UART_RX_FIFO_EN undefined:
//     - Storage is a single holding register.
//     - valid stays high until the word pops.
//     - A push while valid && !ready drops the new word, keeps the old one and pulses overrun.
// TESTING (CLK_DIV=16, DATA_BITS=8, PARITY=2, STOP_BITS=1 unless noted)
//   1. Frame 0xA5 with even parity bit 0 and stop 1 -> data_out=8'hA5, valid, both errs 0,
//      valid rises 1 clk after the stop sample.
//   2. Low glitch of 5 clk on an idle line -> returns to IDLE at the half-bit point;
//      valid stays 0; busy pulses for ~10 clk including synchroniser delay.
//   3. Frame 0x3C with parity bit 1 -> parity_err=1, data_out=8'h3C. Frame 0x3C with stop
//      bit 0 -> frame_err=1.
//   4. ready=0 and 3 frames 0x01,0x02,0x03. Without FIFO: data_out stays 0x01, and overrun
//      pulses twice. With FIFO_DEPTH=2: 0x01 and 0x02 are held, one overrun pulse.
//   5. Back-to-back frames 0x55 and 0xAA with zero idle gap -> both received in order.
//      With PARITY=0 and STOP_BITS=2, a frame with a low second stop bit -> frame_err=1.
//   6. rst_n pulsed low during DATA bit 4 -> all outputs are 0 immediately. The next clean
//      frame 0x7E is received correctly.

Source files
------------

// File: rtl/uart_rx_if.sv
// Received-word handshake between the UART receiver and its consumer.
// The receiver drives the word and its flags; the consumer drives ready.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data_out;
  logic                 valid;
  logic                 ready;
  logic                 frame_err;
  logic                 parity_err;

  modport master (output data_out, valid, frame_err, parity_err, input ready);
  modport slave  (input data_out, valid, frame_err, parity_err, output ready);
endinterface

// File: rtl/uart_rx_core.sv
// Parametrised UART receiver: 2-FF synchroniser, mid-bit sampling, parity/framing flags.
// Define UART_RX_FIFO_EN for a FIFO_DEPTH-entry word FIFO; otherwise a single holding register.
//
// state | meaning
// IDLE  | waiting for a low line (or for the line to go high again after a break)
// START | confirming the start bit at the half-bit point
// DATA  | sampling DATA_BITS payload bits, LSB first
// PAR   | sampling the parity bit
// STOP  | sampling STOP_BITS stop bits, then pushing the word
module uart_rx_core #(
  parameter int CLK_DIV    = 868,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      data_in,
  uart_rx_if.master rx,
  output logic      overrun,
  output logic      busy
);

  localparam int                CNT_W    = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'((CLK_DIV / 2) - 1);
  localparam int                ENT_W    = DATA_BITS + 2;

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t               state, state_n;
  logic [1:0]           sync_q;
  logic                 rx_s;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [3:0]           bit_idx, bit_idx_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic                 perr_q, perr_n;
  logic                 ferr_q, ferr_n;
  logic                 brk_q, brk_n;
  logic                 push;
  logic [ENT_W-1:0]     entry;
  logic [ENT_W-1:0]     head;
  logic                 has_word;
  logic                 pop;
  logic                 accept;
  logic                 drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], data_in};
  end
  assign rx_s = sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      brk_q   <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
      perr_q  <= perr_n;
      ferr_q  <= ferr_n;
      brk_q   <= brk_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    perr_n    = perr_q;
    ferr_n    = ferr_q;
    brk_n     = brk_q;
    push      = 1'b0;
    case (state)
      IDLE: begin
        cnt_n     = '0;
        bit_idx_n = '0;
        // After a break the line must return high before a new start is accepted
        if (brk_q) begin
          if (rx_s) brk_n = 1'b0;
        end else if (!rx_s) begin
          state_n = START;
          perr_n  = 1'b0;
          ferr_n  = 1'b0;
        end
      end
      START: begin
        if (cnt == CNT_HALF) begin
          cnt_n   = '0;
          state_n = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == CNT_LAST) begin
          shift_n = {rx_s, shift[DATA_BITS-1:1]};
          if (bit_idx == 4'(DATA_BITS - 1)) begin
            bit_idx_n = '0;
            state_n   = (PARITY != 0) ? PAR : STOP;
          end else begin
            bit_idx_n = bit_idx + 1'b1;
          end
        end
      end
      PAR: begin
        if (cnt == CNT_LAST) begin
          perr_n  = (PARITY == 1) ? ~(^shift ^ rx_s) : (^shift ^ rx_s);
          state_n = STOP;
        end
      end
      STOP: begin
        if (cnt == CNT_LAST) begin
          if (!rx_s) ferr_n = 1'b1;
          if (bit_idx == 4'(STOP_BITS - 1)) begin
            push      = 1'b1;
            state_n   = IDLE;
            bit_idx_n = '0;
            brk_n     = ~rx_s;
          end else begin
            bit_idx_n = bit_idx + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // The final stop sample is folded in directly since ferr_q lags by one cycle
  assign entry = {ferr_q | ~rx_s, perr_q, shift};

`ifdef UART_RX_FIFO_EN
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [ENT_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W:0]   wptr, rptr;
  logic             empty, full;

  assign empty    = (wptr == rptr);
  assign full     = (wptr[PTR_W] != rptr[PTR_W]) && (wptr[PTR_W-1:0] == rptr[PTR_W-1:0]);
  assign has_word = ~empty;
  assign pop      = has_word & rx.ready;
  assign accept   = push & (~full | pop);
  assign drop     = push & full & ~pop;
  assign head     = mem[rptr[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (accept) mem[wptr[PTR_W-1:0]] <= entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (accept) wptr <= wptr + 1'b1;
      if (pop)    rptr <= rptr + 1'b1;
    end
  end
`else
  logic [ENT_W-1:0] hold;
  logic             hold_v;

  assign has_word = hold_v;
  assign pop      = hold_v & rx.ready;
  assign accept   = push & (~hold_v | pop);
  assign drop     = push & hold_v & ~pop;
  assign head     = hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold   <= '0;
      hold_v <= 1'b0;
    end else if (accept) begin
      hold   <= entry;
      hold_v <= 1'b1;
    end else if (pop) begin
      hold_v <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overrun <= 1'b0;
    else        overrun <= drop;
  end

  // Outputs are gated by valid so stale storage never leaks out
  assign rx.valid      = has_word;
  assign rx.data_out   = has_word ? head[DATA_BITS-1:0] : '0;
  assign rx.parity_err = has_word & head[DATA_BITS];
  assign rx.frame_err  = has_word & head[DATA_BITS+1];
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: vector table of frames plus hand-written corner sequences.
module tb_uart_rx_core;
  localparam int CD = 16;
`ifdef UART_RX_FIFO_EN
  localparam int FD      = 2;
  localparam int EXP_OVR = 1;
`else
  localparam int FD      = 8;
  localparam int EXP_OVR = 2;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic data_in = 1'b1;
  logic data_in2 = 1'b1;
  logic ovr1, busy1, ovr2, busy2;

  uart_rx_if #(.DATA_BITS(8)) rx1 ();
  uart_rx_if #(.DATA_BITS(8)) rx2 ();

  uart_rx_core #(.CLK_DIV(CD), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(FD)) u_dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .rx(rx1), .overrun(ovr1), .busy(busy1));

  uart_rx_core #(.CLK_DIV(CD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(FD)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in2), .rx(rx2), .overrun(ovr2), .busy(busy2));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int ovr_cnt = 0;
  bit mon_en = 1'b0;
  logic [7:0] got_q [$];

  always @(negedge clk) begin
    if (ovr1) ovr_cnt++;
    if (mon_en && rx1.valid && rx1.ready) got_q.push_back(rx1.data_out);
  end

  typedef struct {
    logic [7:0] d;
    logic       pb;
    logic       sb;
    logic [7:0] exp_d;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_line(input bit sel, input logic v);
    if (sel) data_in2 = v;
    else     data_in  = v;
  endtask

  task automatic send(input bit sel, input logic [7:0] d, input bit has_par, input logic pb,
                      input int nstop, input logic s1, input logic s2);
    set_line(sel, 1'b0);
    repeat (CD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      set_line(sel, d[i]);
      repeat (CD) @(negedge clk);
    end
    if (has_par) begin
      set_line(sel, pb);
      repeat (CD) @(negedge clk);
    end
    set_line(sel, s1);
    repeat (CD) @(negedge clk);
    if (nstop == 2) begin
      set_line(sel, s2);
      repeat (CD) @(negedge clk);
    end
    set_line(sel, 1'b1);
  endtask

  task automatic wait_valid(input bit sel, input string name);
    int k = 0;
    while (((sel ? rx2.valid : rx1.valid) !== 1'b1) && k < 600) begin
      @(negedge clk);
      k++;
    end
    chk(name, sel ? rx2.valid : rx1.valid, 1'b1);
  endtask

  task automatic pop(input bit sel);
    if (sel) rx2.ready = 1'b1;
    else     rx1.ready = 1'b1;
    @(negedge clk);
    rx1.ready = 1'b0;
    rx2.ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0};
    vecs[2] = '{8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1};
    vecs[3] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[4] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[5] = '{8'h7F, 1'b1, 1'b1, 8'h7F, 1'b0, 1'b0};
    vecs[6] = '{8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0};
    vecs[7] = '{8'hC3, 1'b1, 1'b0, 8'hC3, 1'b1, 1'b1};

    rx1.ready = 1'b0;
    rx2.ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {rx1.data_out, rx1.valid, rx1.frame_err, rx1.parity_err, ovr1, busy1}, '0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Latency: valid must rise exactly after the 171st clock following the start edge
    fork
      send(1'b0, 8'hA5, 1'b1, 1'b0, 1, 1'b1, 1'b1);
      begin
        repeat (170) @(negedge clk);
        chk("latency_before", rx1.valid, 1'b0);
        @(negedge clk);
        chk("latency_after", rx1.valid, 1'b1);
      end
    join
    chk("latency_data", rx1.data_out, 8'hA5);
    pop(1'b0);
    repeat (20) @(negedge clk);

    // False start
    data_in = 1'b0;
    repeat (5) @(negedge clk);
    data_in = 1'b1;
    chk("glitch_busy_on", busy1, 1'b1);
    repeat (5) @(negedge clk);
    chk("glitch_busy_mid", busy1, 1'b1);
    @(negedge clk);
    chk("glitch_busy_off", busy1, 1'b0);
    repeat (200) @(negedge clk);
    chk("glitch_no_valid", rx1.valid, 1'b0);

    for (int i = 0; i < 8; i++) begin
      send(1'b0, vecs[i].d, 1'b1, vecs[i].pb, 1, vecs[i].sb, 1'b1);
      wait_valid(1'b0, "vec_valid");
      chk($sformatf("vec%0d_data", i), rx1.data_out, vecs[i].exp_d);
      chk($sformatf("vec%0d_perr", i), rx1.parity_err, vecs[i].exp_perr);
      chk($sformatf("vec%0d_ferr", i), rx1.frame_err, vecs[i].exp_ferr);
      pop(1'b0);
      chk($sformatf("vec%0d_popped", i), rx1.valid, 1'b0);
      repeat (20) @(negedge clk);
    end

    // Overrun with ready held low
    ovr_cnt = 0;
    send(1'b0, 8'h01, 1'b1, 1'b1, 1, 1'b1, 1'b1);
    send(1'b0, 8'h02, 1'b1, 1'b1, 1, 1'b1, 1'b1);
    send(1'b0, 8'h03, 1'b1, 1'b0, 1, 1'b1, 1'b1);
    repeat (20) @(negedge clk);
    chk("overrun_count", ovr_cnt, EXP_OVR);
    chk("overrun_head", rx1.data_out, 8'h01);
    pop(1'b0);
`ifdef UART_RX_FIFO_EN
    chk("overrun_second", rx1.data_out, 8'h02);
    pop(1'b0);
`endif
    chk("overrun_drained", rx1.valid, 1'b0);
    repeat (20) @(negedge clk);

    // Back-to-back frames, no idle gap, consumer always ready
    got_q.delete();
    mon_en = 1'b1;
    rx1.ready = 1'b1;
    send(1'b0, 8'h55, 1'b1, 1'b0, 1, 1'b1, 1'b1);
    send(1'b0, 8'hAA, 1'b1, 1'b0, 1, 1'b1, 1'b1);
    repeat (40) @(negedge clk);
    rx1.ready = 1'b0;
    mon_en = 1'b0;
    chk("b2b_count", got_q.size(), 2);
    if (got_q.size() >= 2) begin
      chk("b2b_first", got_q[0], 8'h55);
      chk("b2b_second", got_q[1], 8'hAA);
    end

    // Two stop bits, no parity
    send(1'b1, 8'h96, 1'b0, 1'b0, 2, 1'b1, 1'b0);
    wait_valid(1'b1, "stop2_valid");
    chk("stop2_data", rx2.data_out, 8'h96);
    chk("stop2_ferr", rx2.frame_err, 1'b1);
    chk("stop2_perr", rx2.parity_err, 1'b0);
    pop(1'b1);
    repeat (20) @(negedge clk);
    send(1'b1, 8'h69, 1'b0, 1'b0, 2, 1'b1, 1'b1);
    wait_valid(1'b1, "stop2ok_valid");
    chk("stop2ok_data", rx2.data_out, 8'h69);
    chk("stop2ok_ferr", rx2.frame_err, 1'b0);
    pop(1'b1);

    // Break: line held low yields exactly one zero word with frame_err
    repeat (20) @(negedge clk);
    ovr_cnt = 0;
    data_in = 1'b0;
    repeat (25 * CD) @(negedge clk);
    chk("break_valid", rx1.valid, 1'b1);
    chk("break_data", rx1.data_out, 8'h00);
    chk("break_ferr", rx1.frame_err, 1'b1);
    chk("break_overrun", ovr_cnt, 0);
    chk("break_idle", busy1, 1'b0);
    data_in = 1'b1;
    repeat (10) @(negedge clk);
    pop(1'b0);
    chk("break_single", rx1.valid, 1'b0);
    repeat (20) @(negedge clk);

    // Reset mid-frame with a stored word pending
    send(1'b0, 8'h11, 1'b1, 1'b0, 1, 1'b1, 1'b1);
    wait_valid(1'b0, "pre_reset_valid");
    data_in = 1'b0;
    repeat (CD) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      data_in = i[0];
      repeat (CD) @(negedge clk);
    end
    data_in = 1'b1;
    repeat (CD / 2) @(negedge clk);
    chk("pre_reset_busy", busy1, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("reset_mid_outputs", {rx1.data_out, rx1.valid, rx1.frame_err, rx1.parity_err, ovr1, busy1}, '0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    send(1'b0, 8'h7E, 1'b1, 1'b0, 1, 1'b1, 1'b1);
    wait_valid(1'b0, "post_reset_valid");
    chk("post_reset_data", rx1.data_out, 8'h7E);
    chk("post_reset_errs", {rx1.frame_err, rx1.parity_err}, 2'b00);
    pop(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
